// File: rtl/dtw_core_sequencer.sv
// dtw_core_sequencer
// Job sequencer sitting in front of dtw_core_datapath. A job clears the core,
// buffers one query squiggle from a valid/ready stream, then streams reference
// samples from a 1-cycle-latency read port while keeping the core running, and
// finally hands the core's minimum cost and end position back on a valid/ready
// result port.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                job request (honoured in IDLE only)
//   ref_base, ref_len    reference window, captured on accepted start
//   q_data/q_valid/q_ready  query sample stream (accepted in LOADQ only)
//   ref_addr/ref_en      reference read request
//   ref_rdata            read data, one cycle after ref_en
//   core_*               drive / observe the DTW core
//   res_valid/res_ready  result handshake, res_minval/res_position payload
//   busy                 high whenever a job is in flight
module dtw_core_sequencer #(
  parameter int unsigned width    = 16,
  parameter int unsigned SQG_SIZE = 250,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] ref_base,
  input  logic [31:0]       ref_len,
  input  logic [width-1:0]  q_data,
  input  logic              q_valid,
  output logic              q_ready,
  output logic [ADDR_W-1:0] ref_addr,
  output logic              ref_en,
  input  logic [width-1:0]  ref_rdata,
  output logic              core_rst,
  output logic              core_running,
  output logic [width-1:0]  core_squiggle,
  output logic [width-1:0]  core_rword,
  output logic [31:0]       core_ref_len,
  input  logic              core_done,
  input  logic [width-1:0]  core_minval,
  input  logic [31:0]       core_position,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [width-1:0]  res_minval,
  output logic [31:0]       res_position,
  output logic              busy
);

  // Counter widths: scnt must be able to reach SQG_SIZE, the buffer index does not.
  localparam int unsigned QW = $clog2(SQG_SIZE + 1);
  localparam int unsigned IW = (SQG_SIZE > 1) ? $clog2(SQG_SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOADQ,
    S_PREF,
    S_RUN,
    S_SETTLE,
    S_RESULT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] base_q;
  logic [31:0]       len_q;
  logic [QW-1:0]     qcnt;
  logic [QW-1:0]     scnt;
  logic [31:0]       rcnt;
  logic              settle_second;
  logic              pend;
  logic [width-1:0]  qbuf [SQG_SIZE];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; everything collapses to reset values while rst is high
  always_comb begin
    state_nxt     = state;
    core_rst      = rst;
    q_ready       = 1'b0;
    ref_en        = 1'b0;
    ref_addr      = '0;
    core_running  = 1'b0;
    core_squiggle = '0;
    core_rword    = '0;
    res_valid     = 1'b0;

    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_CLEAR;
          end
        end

        S_CLEAR: begin
          core_rst  = 1'b1;
          state_nxt = (len_q == 32'd0) ? S_RESULT : S_LOADQ;
        end

        S_LOADQ: begin
          q_ready = 1'b1;
          if (q_valid && (qcnt == QW'(SQG_SIZE - 1))) begin
            state_nxt = S_PREF;
          end
        end

        // Prime the read pipe so reference sample 0 lands on the first RUN cycle
        S_PREF: begin
          ref_en    = 1'b1;
          ref_addr  = base_q;
          state_nxt = S_RUN;
        end

        S_RUN: begin
          // Unread positions are padded with all ones so they never look like a match
          core_rword = pend ? ref_rdata : '1;
          if (scnt < QW'(SQG_SIZE)) begin
            core_squiggle = qbuf[IW'(scnt)];
          end
          if (rcnt < len_q) begin
            ref_en   = 1'b1;
            ref_addr = base_q + ADDR_W'(rcnt);
          end
          if (core_done) begin
            state_nxt = S_SETTLE;
          end else begin
            core_running = 1'b1;
          end
        end

        // Two idle cycles let the core's minimum register finish its last update
        S_SETTLE: begin
          if (settle_second) begin
            state_nxt = S_RESULT;
          end
        end

        S_RESULT: begin
          res_valid = 1'b1;
          if (res_ready) begin
            state_nxt = S_IDLE;
          end
        end

        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign busy         = (state != S_IDLE);
  assign core_ref_len = len_q;

  // Job registers, counters and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q        <= '0;
      len_q         <= '0;
      qcnt          <= '0;
      scnt          <= '0;
      rcnt          <= '0;
      settle_second <= 1'b0;
      pend          <= 1'b0;
      res_minval    <= '1;
      res_position  <= '0;
    end else begin
      // A read issued this cycle returns data next cycle
      pend <= ref_en;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q <= ref_base;
            len_q  <= ref_len;
          end
        end

        S_CLEAR: begin
          qcnt          <= '0;
          scnt          <= '0;
          rcnt          <= '0;
          settle_second <= 1'b0;
          // Empty reference: report "no match" without running the core
          if (len_q == 32'd0) begin
            res_minval   <= '1;
            res_position <= '0;
          end
        end

        S_LOADQ: begin
          if (q_valid && q_ready) begin
            qcnt <= qcnt + QW'(1);
          end
        end

        S_PREF: begin
          rcnt <= 32'd1;
        end

        S_RUN: begin
          if (ref_en) begin
            rcnt <= rcnt + 32'd1;
          end
          if (scnt < QW'(SQG_SIZE)) begin
            scnt <= scnt + QW'(1);
          end
        end

        S_SETTLE: begin
          settle_second <= ~settle_second;
          if (settle_second) begin
            res_minval   <= core_minval;
            res_position <= core_position;
          end
        end

        default: begin
        end
      endcase
    end
  end

  // Query buffer; contents are meaningless until reloaded, so no reset is needed
  always_ff @(posedge clk) begin
    if ((state == S_LOADQ) && q_valid && q_ready) begin
      qbuf[IW'(qcnt)] <= q_data;
    end
  end

endmodule

// File: tb/tb_dtw_core_sequencer.sv
// Scoreboard bench for dtw_core_sequencer. A behavioural core model consumes
// what the sequencer feeds it and answers with an sDTW result; expected job
// results are computed from the stimulus and checked by a separate monitor.
module tb_dtw_core_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned S     = 4;
  localparam int unsigned AW    = 32;

  typedef struct packed {
    logic [15:0] mv;
    logic [31:0] pos;
  } res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] ref_base;
  logic [31:0]   ref_len;
  logic [15:0]   q_data;
  logic          q_valid;
  logic          q_ready;
  logic [AW-1:0] ref_addr;
  logic          ref_en;
  logic [15:0]   ref_rdata;
  logic          core_rst;
  logic          core_running;
  logic [15:0]   core_squiggle;
  logic [15:0]   core_rword;
  logic [31:0]   core_ref_len;
  logic          core_done;
  logic [15:0]   core_minval;
  logic [31:0]   core_position;
  logic          res_valid;
  logic          res_ready;
  logic [15:0]   res_minval;
  logic [31:0]   res_position;
  logic          busy;

  dtw_core_sequencer #(.width(WIDTH), .SQG_SIZE(S), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .ref_base(ref_base), .ref_len(ref_len),
    .q_data(q_data), .q_valid(q_valid), .q_ready(q_ready),
    .ref_addr(ref_addr), .ref_en(ref_en), .ref_rdata(ref_rdata),
    .core_rst(core_rst), .core_running(core_running), .core_squiggle(core_squiggle),
    .core_rword(core_rword), .core_ref_len(core_ref_len), .core_done(core_done),
    .core_minval(core_minval), .core_position(core_position),
    .res_valid(res_valid), .res_ready(res_ready), .res_minval(res_minval),
    .res_position(res_position), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [logic [31:0]];
  int          cur_q[$];
  logic [31:0] cur_base = '0;
  int          cur_len = 0;
  logic [31:0] addr_log[$];
  res_t        exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic logic [15:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'hDEAD;
  endfunction

  // Subsequence DTW: free start anywhere in the reference, |q-r| cost,
  // result is the cheapest full-query alignment and its 1-based end index.
  function automatic res_t sdtw(input int q[$], input int r[$]);
    int   prev[$];
    int   cur[$];
    int   c, m, best, pos;
    res_t res;
    best = 32'hFFFF;
    pos  = 0;
    if (r.size() != 0 && q.size() != 0) begin
      for (int i = 0; i < q.size(); i++) begin
        cur.delete();
        for (int j = 0; j < r.size(); j++) begin
          c = (q[i] > r[j]) ? q[i] - r[j] : r[j] - q[i];
          if (i == 0) m = 0;
          else if (j == 0) m = prev[0];
          else begin
            m = prev[j];
            if (cur[j-1] < m) m = cur[j-1];
            if (prev[j-1] < m) m = prev[j-1];
          end
          cur.push_back(c + m);
        end
        prev = cur;
      end
      for (int j = 0; j < prev.size(); j++) begin
        if (prev[j] < best) begin
          best = prev[j];
          pos  = j + 1;
        end
      end
    end
    res.mv  = 16'(best);
    res.pos = 32'(pos);
    return res;
  endfunction

  function automatic res_t golden(input logic [31:0] base, input int len);
    int r[$];
    for (int k = 0; k < len; k++) r.push_back(int'(mem_rd(base + 32'(k))));
    return sdtw(cur_q, r);
  endfunction

  // Behavioural core + reference memory
  initial begin
    int          rc, extra, dstage;
    int          rq[$];
    int          rr[$];
    res_t        cres;
    logic [15:0] rd_n;
    rc = 0; extra = 0; dstage = 0; cres = '0;
    core_done = 1'b0; core_minval = '0; core_position = '0; ref_rdata = '0;
    forever begin
      @(negedge clk);
      if (core_rst) begin
        rc = 0; dstage = 0;
        rq.delete(); rr.delete();
        extra = int'($urandom_range(0, 3));
      end else if (core_running) begin
        if (rc == 0) chk("core_ref_len", 64'(core_ref_len), 64'(cur_len));
        if (rc < cur_len) chk("rword", 64'(core_rword), 64'(mem_rd(cur_base + 32'(rc))));
        else chk("rword_pad", 64'(core_rword), 64'h FFFF);
        if (rc < int'(S)) chk("squiggle", 64'(core_squiggle), 64'(cur_q[rc]));
        else chk("squiggle_pad", 64'(core_squiggle), 64'h0);
        if (rc < int'(core_ref_len)) rr.push_back(int'(core_rword));
        if (rc < int'(S)) rq.push_back(int'(core_squiggle));
        rc++;
        if (dstage == 0 && rc >= int'(core_ref_len) + int'(S) + extra) begin
          dstage = 1;
          cres = sdtw(rq, rr);
        end
      end else if (dstage > 0 && dstage < 3) begin
        dstage++;
      end
      if (ref_en) addr_log.push_back(ref_addr);
      rd_n = ref_en ? mem_rd(ref_addr) : 16'($urandom);
      @(posedge clk); #1;
      ref_rdata     = rd_n;
      core_done     = (dstage != 0);
      // Minimum only settles two cycles after done; earlier values are junk
      core_minval   = (dstage == 3) ? cres.mv  : 16'($urandom);
      core_position = (dstage == 3) ? cres.pos : 32'($urandom);
    end
  end

  // Result monitor: every valid cycle must show the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          chk("res_minval", 64'(res_minval), 64'(exp_q[0].mv));
          chk("res_position", 64'(res_position), 64'(exp_q[0].pos));
          if (res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic recover();
    tick(); rst = 1'b1; start = 1'b0; q_valid = 1'b0; res_ready = 1'b0;
    tick(); rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_query_rand();
    cur_q.delete();
    for (int i = 0; i < int'(S); i++) cur_q.push_back(int'($urandom_range(0, 15)));
  endtask

  task automatic fill_ref(input logic [31:0] base, input int len);
    for (int k = 0; k < len; k++) mem[base + 32'(k)] = 16'($urandom_range(0, 15));
  endtask

  // qmode: 0 = q_valid held high, 1 = toggling 1,0,1,0, 2 = random
  task automatic run_job(input logic [31:0] base, input int len, input int qmode,
                         input int abort_at, input bit hold, input bit push_golden);
    int t0, hs, guard, d_cyc;
    bit seen_done;
    cur_base = base;
    cur_len  = len;
    if (push_golden && abort_at == 0) exp_q.push_back(golden(base, len));

    tick(); res_ready = 1'b0; start = 1'b1; ref_base = base; ref_len = 32'(len); t0 = cyc;
    @(negedge clk); chk("idle_before_start", 64'(busy), 64'h0);

    tick(); start = 1'b0; ref_base = $urandom; ref_len = $urandom;
    @(negedge clk);
    chk("clear_core_rst", 64'(core_rst), 64'h1);
    chk("clear_busy", 64'(busy), 64'h1);
    chk("clear_ref_len", 64'(core_ref_len), 64'(len));

    if (len == 0) begin
      tick();
      @(negedge clk);
      chk("len0_latency", 64'(res_valid), 64'h1);
      chk("len0_running", 64'(core_running), 64'h0);
    end else begin
      hs = 0; guard = 0;
      while (hs < int'(S) && guard < 100) begin
        tick(); guard++;
        case (qmode)
          0: q_valid = 1'b1;
          1: q_valid = (guard % 2 == 1);
          default: q_valid = 1'($urandom_range(0, 1));
        endcase
        q_data = q_valid ? 16'(cur_q[hs]) : 16'($urandom);
        @(negedge clk);
        chk("loadq_ready", 64'(q_ready), 64'h1);
        chk("loadq_running", 64'(core_running), 64'h0);
        chk("loadq_ref_en", 64'(ref_en), 64'h0);
        if (q_valid && q_ready) hs++;
      end
      if (hs < int'(S)) begin
        fail_now("loadq_timeout");
        recover();
        return;
      end

      tick(); q_valid = 1'b1; q_data = 16'hBEEF;
      @(negedge clk);
      chk("pref_ref_en", 64'(ref_en), 64'h1);
      chk("pref_addr", 64'(ref_addr), 64'(base));
      chk("pref_q_ready", 64'(q_ready), 64'h0);
      chk("pref_running", 64'(core_running), 64'h0);
      if (qmode == 0) chk("pref_time", 64'(cyc - t0), 64'(2 + S));

      guard = 0; seen_done = 1'b0; d_cyc = 0;
      do begin
        tick(); guard++;
        q_valid = 1'($urandom_range(0, 1)); q_data = 16'($urandom);
        if (abort_at != 0 && guard == abort_at) rst = 1'b1;
        @(negedge clk);
        chk("run_q_ready", 64'(q_ready), 64'h0);
        if (rst) begin
          chk("rst_core_rst", 64'(core_rst), 64'h1);
          chk("rst_res_valid", 64'(res_valid), 64'h0);
          tick(); rst = 1'b0; q_valid = 1'b0;
          @(negedge clk);
          chk("rst_idle", 64'(busy), 64'h0);
          chk("rst_running", 64'(core_running), 64'h0);
          chk("rst_core_rst_release", 64'(core_rst), 64'h0);
          return;
        end
        if (guard == 1) begin
          chk("run_first", 64'(core_running), 64'h1);
          if (qmode == 0) chk("run_time", 64'(cyc - t0), 64'(3 + S));
        end
        if (core_done && !seen_done) begin
          seen_done = 1'b1;
          d_cyc = cyc;
          chk("exit_running", 64'(core_running), 64'h0);
        end else if (!seen_done) begin
          chk("run_running", 64'(core_running), 64'h1);
        end
      end while (!res_valid && guard < 400);
      q_valid = 1'b0;
      if (!res_valid) begin
        fail_now("result_timeout");
        recover();
        return;
      end
      chk("res_latency", 64'(cyc - d_cyc), 64'h3);
    end

    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        tick(); start = (i % 2 == 0);
        @(negedge clk);
        chk("hold_valid", 64'(res_valid), 64'h1);
        chk("hold_busy", 64'(busy), 64'h1);
      end
      start = 1'b0;
    end else begin
      repeat ($urandom_range(0, 3)) begin
        tick();
        @(negedge clk);
        chk("wait_valid", 64'(res_valid), 64'h1);
      end
    end
    // Acceptance cycle; start here must be ignored, next job starts right after
    tick(); res_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("accept_valid", 64'(res_valid), 64'h1);
    chk("accept_running", 64'(core_running), 64'h0);
  endtask

  initial begin
    logic [31:0] b;
    int          l;
    rst = 1'b1; start = 1'b0; q_valid = 1'b0; q_data = '0; res_ready = 1'b0;
    ref_base = '0; ref_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_core_rst", 64'(core_rst), 64'h1);
    chk("reset_res_minval", 64'(res_minval), 64'hFFFF);
    chk("reset_res_position", 64'(res_position), 64'h0);
    chk("reset_res_valid", 64'(res_valid), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_q_ready", 64'(q_ready), 64'h0);
    chk("reset_ref_en", 64'(ref_en), 64'h0);
    chk("reset_running", 64'(core_running), 64'h0);
    chk("reset_ref_len", 64'(core_ref_len), 64'h0);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("post_reset_core_rst", 64'(core_rst), 64'h0);

    // Reference example: query 1..4 matches reference positions 1..4
    cur_q = '{1, 2, 3, 4};
    mem[32'h100] = 16'd9; mem[32'h101] = 16'd1; mem[32'h102] = 16'd2;
    mem[32'h103] = 16'd3; mem[32'h104] = 16'd4; mem[32'h105] = 16'd9;
    exp_q.push_back('{mv: 16'h0, pos: 32'd5});
    run_job(32'h100, 6, 0, 0, 1'b0, 1'b0);

    // Toggling q_valid during load
    set_query_rand(); fill_ref(32'h2000, 5);
    run_job(32'h2000, 5, 1, 0, 1'b0, 1'b1);

    // Address wrap across 2^32
    set_query_rand(); fill_ref(32'hFFFF_FFFE, 4);
    addr_log.delete();
    run_job(32'hFFFF_FFFE, 4, 0, 0, 1'b0, 1'b1);
    chk("wrap_reads", 64'(addr_log.size()), 64'h4);
    if (addr_log.size() == 4) begin
      chk("wrap_addr0", 64'(addr_log[0]), 64'hFFFF_FFFE);
      chk("wrap_addr1", 64'(addr_log[1]), 64'hFFFF_FFFF);
      chk("wrap_addr2", 64'(addr_log[2]), 64'h0);
      chk("wrap_addr3", 64'(addr_log[3]), 64'h1);
    end

    // Empty reference
    exp_q.push_back('{mv: 16'hFFFF, pos: 32'd0});
    run_job(32'h3000, 0, 0, 0, 1'b0, 1'b0);

    // Reset mid-run, then the reference example again
    cur_q = '{1, 2, 3, 4};
    run_job(32'h100, 6, 0, 3, 1'b0, 1'b0);
    exp_q.push_back('{mv: 16'h0, pos: 32'd5});
    run_job(32'h100, 6, 0, 0, 1'b0, 1'b0);

    // Backpressured result with start pulses
    set_query_rand(); fill_ref(32'h4000, 7);
    run_job(32'h4000, 7, 2, 0, 1'b1, 1'b1);

    // Randomized jobs
    for (int n = 0; n < 20; n++) begin
      set_query_rand();
      b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : 32'($urandom);
      l = int'($urandom_range(1, 10));
      fill_ref(b, l);
      run_job(b, l, 2, 0, 1'b0, 1'b1);
    end

    tick(); start = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    chk("final_idle", 64'(busy), 64'h0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
